// File: rtl/mem_pkg.sv
// mem_pkg: shared types and default widths for the two-port memory arbiter
package mem_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 64;
  typedef enum logic [1:0] {IDLE, ACTIVE, RESP} arb_state_e;
  typedef enum logic {READ, WRITE} mem_op_e;
endpackage

// File: rtl/arb_pick2.sv
// arb_pick2: combinational two-way grant select
//   req[1:0] requests, ptr preferred port on a tie, valid any request, gnt granted port
module arb_pick2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       valid,
  output logic       gnt
);
  assign valid = |req;
  assign gnt   = &req ? ptr : req[1];
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between two requesters, one transaction at a time
//   clk/rst (async, active-high); pk_* requester ports for k=0,1; mem_* memory port
//   MEM_ARB_ROUND_ROBIN_EN: ties go to the port not granted last (else port 0 wins)
module mem_arbiter import mem_pkg::*; #(
  parameter int AddrBusWidth = ADDR_W_DEF,
  parameter int MemBusWidth  = DATA_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [AddrBusWidth-1:0] p0_addr,
  input  logic [MemBusWidth-1:0]  p0_w_data,
  input  logic                    p0_re,
  input  logic                    p0_we,
  output logic [MemBusWidth-1:0]  p0_r_data,
  output logic                    p0_busy,
  output logic                    p0_done,
  input  logic [AddrBusWidth-1:0] p1_addr,
  input  logic [MemBusWidth-1:0]  p1_w_data,
  input  logic                    p1_re,
  input  logic                    p1_we,
  output logic [MemBusWidth-1:0]  p1_r_data,
  output logic                    p1_busy,
  output logic                    p1_done,
  output logic [AddrBusWidth-1:0] mem_addr,
  output logic [MemBusWidth-1:0]  mem_w_data,
  output logic                    mem_re,
  output logic                    mem_we,
  input  logic [MemBusWidth-1:0]  mem_r_data,
  input  logic                    mem_busy,
  input  logic                    mem_done
);
  arb_state_e state;
  mem_op_e op;
  logic owner, ptr, gnt_valid, gnt, grant;
  logic [AddrBusWidth-1:0] addr_q;
  logic [MemBusWidth-1:0] wdata_q;
  logic req0, req1, active, resp;
  assign req0 = p0_re | p0_we;
  assign req1 = p1_re | p1_we;
  arb_pick2 u_pick (.req({req1, req0}), .ptr(ptr), .valid(gnt_valid), .gnt(gnt));
  assign grant = state == IDLE && gnt_valid && !mem_busy;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr <= 1'b0;
    else if (grant) ptr <= ~gnt;
`else
  assign ptr = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      owner <= 1'b0;
      op <= READ;
      addr_q <= '0;
      wdata_q <= '0;
      p0_r_data <= '0;
      p1_r_data <= '0;
    end else begin
      case (state)
        IDLE: if (grant) begin
          state <= ACTIVE;
          owner <= gnt;
          addr_q <= gnt ? p1_addr : p0_addr;
          wdata_q <= gnt ? p1_w_data : p0_w_data;
          op <= (gnt ? p1_we : p0_we) ? WRITE : READ;
        end
        ACTIVE: if (mem_done) begin
          state <= RESP;
          if (op == READ && owner) p1_r_data <= mem_r_data;
          if (op == READ && !owner) p0_r_data <= mem_r_data;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign active = state == ACTIVE;
  assign resp = state == RESP;
  assign mem_re = active && op == READ;
  assign mem_we = active && op == WRITE;
  assign mem_addr = active ? addr_q : '0;
  assign mem_w_data = active ? wdata_q : '0;
  assign p0_done = resp && !owner;
  assign p1_done = resp && owner;
  // busy is gated by rst so it reads 0 while reset is held, even with a request up
  assign p0_busy = req0 && !p0_done && !rst;
  assign p1_busy = req1 && !p1_done && !rst;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
  logic clk = 0, rst = 1;
  logic [31:0] p0_addr = 0, p1_addr = 0, mem_addr;
  logic [63:0] p0_w_data = 0, p1_w_data = 0, p0_r_data, p1_r_data, mem_w_data, mem_r_data = 0;
  logic p0_re = 0, p0_we = 0, p1_re = 0, p1_we = 0, p0_busy, p0_done, p1_busy, p1_done;
  logic mem_re, mem_we, mem_busy = 0, mem_done = 0, mem_auto = 1, stray = 0;
  int n_checks = 0, n_fail = 0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1;
`else
  localparam bit RR = 0;
`endif
  always #5 clk = ~clk;
  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .p0_addr(p0_addr), .p0_w_data(p0_w_data), .p0_re(p0_re), .p0_we(p0_we),
    .p0_r_data(p0_r_data), .p0_busy(p0_busy), .p0_done(p0_done),
    .p1_addr(p1_addr), .p1_w_data(p1_w_data), .p1_re(p1_re), .p1_we(p1_we),
    .p1_r_data(p1_r_data), .p1_busy(p1_busy), .p1_done(p1_done),
    .mem_addr(mem_addr), .mem_w_data(mem_w_data), .mem_re(mem_re), .mem_we(mem_we),
    .mem_r_data(mem_r_data), .mem_busy(mem_busy), .mem_done(mem_done)
  );
  task automatic tick();
    @(negedge clk);
    mem_done = stray | (mem_auto & (mem_re | mem_we));
  endtask
  task automatic do_reset();
    rst = 1;
    tick();
    rst = 0;
    tick();
  endtask
  task automatic test_reset();
    p0_re = 1;
    tick();
    tick();
    n_checks++; if ({mem_re, mem_we, p0_done, p1_done, p0_busy, p1_busy} !== 6'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b want 000000", {mem_re, mem_we, p0_done, p1_done, p0_busy, p1_busy}); end
    n_checks++; if (mem_addr !== 32'h0 || mem_w_data !== 64'h0) begin n_fail++; $display("FAIL reset_bus: got %h/%h want 0/0", mem_addr, mem_w_data); end
    n_checks++; if (p0_r_data !== 64'h0 || p1_r_data !== 64'h0) begin n_fail++; $display("FAIL reset_rdata: got %h/%h want 0/0", p0_r_data, p1_r_data); end
    p0_re = 0;
    rst = 0;
    tick();
  endtask
  task automatic test_single_read();
    mem_r_data = 64'hDEADBEEF_01234567;
    p0_re = 1; p0_addr = 32'h100;
    tick();
    n_checks++; if (mem_re !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100) begin n_fail++; $display("FAIL read_issue: got re=%b we=%b addr=%h want 1 0 100", mem_re, mem_we, mem_addr); end
    n_checks++; if (p0_busy !== 1'b1 || p0_done !== 1'b0) begin n_fail++; $display("FAIL read_busy: got busy=%b done=%b want 1 0", p0_busy, p0_done); end
    tick();
    n_checks++; if (p0_done !== 1'b1 || p0_busy !== 1'b0 || mem_re !== 1'b0) begin n_fail++; $display("FAIL read_done: got done=%b busy=%b re=%b want 1 0 0", p0_done, p0_busy, mem_re); end
    n_checks++; if (p0_r_data !== 64'hDEADBEEF_01234567) begin n_fail++; $display("FAIL read_data: got %h want deadbeef01234567", p0_r_data); end
    n_checks++; if (p1_done !== 1'b0 || p1_r_data !== 64'h0) begin n_fail++; $display("FAIL read_p1_untouched: got done=%b data=%h want 0 0", p1_done, p1_r_data); end
    p0_re = 0;
    tick();
    n_checks++; if (p0_done !== 1'b0 || mem_addr !== 32'h0 || mem_w_data !== 64'h0) begin n_fail++; $display("FAIL read_idle: got done=%b addr=%h wd=%h want 0 0 0", p0_done, mem_addr, mem_w_data); end
  endtask
  task automatic test_simultaneous();
    do_reset();
    mem_r_data = 64'h1111;
    p0_re = 1; p0_addr = 32'h40;
    p1_we = 1; p1_addr = 32'h80; p1_w_data = 64'hCAFE_F00D;
    tick();
    n_checks++; if (mem_re !== 1'b1 || mem_addr !== 32'h40) begin n_fail++; $display("FAIL sim_first: got re=%b addr=%h want 1 40", mem_re, mem_addr); end
    n_checks++; if (p1_busy !== 1'b1) begin n_fail++; $display("FAIL sim_p1_wait_busy: got %b want 1", p1_busy); end
    tick();
    n_checks++; if (p0_done !== 1'b1 || p1_done !== 1'b0) begin n_fail++; $display("FAIL sim_p0_done: got %b%b want 10", p0_done, p1_done); end
    p0_re = 0;
    tick();
    tick();
    n_checks++; if (mem_we !== 1'b1 || mem_re !== 1'b0 || mem_addr !== 32'h80 || mem_w_data !== 64'hCAFE_F00D) begin n_fail++; $display("FAIL sim_second: got we=%b re=%b addr=%h wd=%h want 1 0 80 cafef00d", mem_we, mem_re, mem_addr, mem_w_data); end
    tick();
    n_checks++; if (p1_done !== 1'b1 || p0_done !== 1'b0 || p1_r_data !== 64'h0 || p0_r_data !== 64'h1111) begin n_fail++; $display("FAIL sim_p1_done: got done=%b%b r1=%h r0=%h want 01 0 1111", p0_done, p1_done, p1_r_data, p0_r_data); end
    p1_we = 0;
    tick();
  endtask
  task automatic test_back_to_back();
    int c0 = 0, c1 = 0, cyc = 0;
    do_reset();
    p0_re = 1; p0_addr = 32'h40;
    p1_re = 1; p1_addr = 32'h80;
    while (c0 + c1 < 20 && cyc < 400) begin
      tick();
      cyc++;
      if (p0_done | p1_done) begin
        n_checks++;
        if (p1_done !== (RR ? 1'((c0 + c1) % 2) : 1'b0)) begin n_fail++; $display("FAIL b2b_order: grant %0d got p1_done=%b", c0 + c1, p1_done); end
        if (p0_done) c0++; else c1++;
      end
    end
    p0_re = 0; p1_re = 0;
    n_checks++; if (cyc >= 400) begin n_fail++; $display("FAIL b2b_timeout: got %0d grants want 20", c0 + c1); end
    n_checks++; if (c0 != (RR ? 10 : 20) || c1 != (RR ? 10 : 0)) begin n_fail++; $display("FAIL b2b_counts: got %0d/%0d want %0d/%0d", c0, c1, RR ? 10 : 20, RR ? 10 : 0); end
    tick();
    tick();
  endtask
  task automatic test_mem_busy();
    mem_busy = 1; mem_r_data = 64'hA5A5;
    p1_re = 1; p1_addr = 32'h200;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if (mem_re !== 1'b0 || p1_busy !== 1'b1) begin n_fail++; $display("FAIL busy_hold%0d: got re=%b busy=%b want 0 1", i, mem_re, p1_busy); end
    end
    mem_busy = 0;
    tick();
    n_checks++; if (mem_re !== 1'b1 || mem_addr !== 32'h200) begin n_fail++; $display("FAIL busy_release: got re=%b addr=%h want 1 200", mem_re, mem_addr); end
    tick();
    n_checks++; if (p1_done !== 1'b1 || p1_r_data !== 64'hA5A5) begin n_fail++; $display("FAIL busy_done: got done=%b data=%h want 1 a5a5", p1_done, p1_r_data); end
    p1_re = 0;
    tick();
  endtask
  task automatic test_reset_mid();
    mem_auto = 0;
    p0_we = 1; p0_addr = 32'h300; p0_w_data = 64'h77;
    tick();
    tick();
    n_checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h300) begin n_fail++; $display("FAIL rstmid_active: got we=%b addr=%h want 1 300", mem_we, mem_addr); end
    rst = 1;
    #1;
    n_checks++; if ({mem_we, mem_re, p0_done, p0_busy} !== 4'b0 || mem_addr !== 32'h0 || mem_w_data !== 64'h0) begin n_fail++; $display("FAIL rstmid_outputs: got ctl=%b addr=%h wd=%h want 0 0 0", {mem_we, mem_re, p0_done, p0_busy}, mem_addr, mem_w_data); end
    n_checks++; if (p1_r_data !== 64'h0) begin n_fail++; $display("FAIL rstmid_rdata: got %h want 0", p1_r_data); end
    tick();
    n_checks++; if (p0_done !== 1'b0) begin n_fail++; $display("FAIL rstmid_nodone: got %b want 0", p0_done); end
    rst = 0; mem_auto = 1;
    tick();
    n_checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h300 || mem_w_data !== 64'h77) begin n_fail++; $display("FAIL rstmid_regrant: got we=%b addr=%h wd=%h want 1 300 77", mem_we, mem_addr, mem_w_data); end
    tick();
    n_checks++; if (p0_done !== 1'b1) begin n_fail++; $display("FAIL rstmid_done: got %b want 1", p0_done); end
    p0_we = 0;
    tick();
  endtask
  task automatic test_stray_done();
    mem_auto = 0; stray = 1; mem_r_data = 64'h9999;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if ({mem_re, mem_we, p0_done, p1_done} !== 4'b0) begin n_fail++; $display("FAIL stray_ignored%0d: got %b want 0000", i, {mem_re, mem_we, p0_done, p1_done}); end
    end
    stray = 0; mem_auto = 1;
    p0_re = 1; p0_we = 1; p0_addr = 32'h44;
    tick();
    n_checks++; if (mem_we !== 1'b1 || mem_re !== 1'b0) begin n_fail++; $display("FAIL stray_we_wins: got we=%b re=%b want 1 0", mem_we, mem_re); end
    p0_re = 0; p0_we = 0;
    tick();
    n_checks++; if (p0_done !== 1'b1 || p0_r_data !== 64'h0) begin n_fail++; $display("FAIL stray_drop_completes: got done=%b data=%h want 1 0", p0_done, p0_r_data); end
    tick();
    n_checks++; if (mem_we !== 1'b0 || p0_done !== 1'b0) begin n_fail++; $display("FAIL stray_idle: got we=%b done=%b want 0 0", mem_we, p0_done); end
  endtask
  initial begin
    test_reset();
    test_single_read();
    test_simultaneous();
    test_back_to_back();
    test_mem_busy();
    test_reset_mid();
    test_stray_done();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
